data_mem_responder: RTL

//  Memory-side responder for the CPU data port: consumes address/WE/write-data and returns byte read data.

---
 rtl/asip_mem_pkg.sv | 20 ++
 rtl/byte_ram_2r1w.sv | 39 +++
 rtl/data_mem_responder.sv | 117 +++++++++++
 3 files changed

// File: rtl/asip_mem_pkg.sv
// Shared types and width helpers for the data-memory responder.
package asip_mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    PRESENT = 2'd2,
    DONE    = 2'd3
  } dump_state_t;

  localparam int DEF_DEPTH = 4096;
  localparam int DEF_L     = 8;
  localparam int DEF_A     = 32;

  // Index width for a power-of-two byte array.
  function automatic int idx_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/byte_ram_2r1w.sv
// Byte RAM with one write port and two registered, write-first read ports.
// Port 1 only updates its output when ren1 is high so a captured value can be held.
module byte_ram_2r1w
  import asip_mem_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int L     = DEF_L,
  localparam int AW   = idx_bits(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [L-1:0]  wdata,
  input  logic [AW-1:0] raddr0,
  output logic [L-1:0]  rdata0,
  input  logic          ren1,
  input  logic [AW-1:0] raddr1,
  output logic [L-1:0]  rdata1
);

  logic [L-1:0] mem [DEPTH];

  // Storage is never reset; contents survive RST.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      rdata0 <= (we && waddr == raddr0) ? wdata : mem[raddr0];
      if (ren1) rdata1 <= (we && waddr == raddr1) ? wdata : mem[raddr1];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// CPU data-port responder: byte RAM with range checking, sticky error flag,
// and a valid/ready dump engine that streams a fixed memory window.
module data_mem_responder
  import asip_mem_pkg::*;
#(
  parameter int DEPTH      = DEF_DEPTH,
  parameter int L          = DEF_L,
  parameter int A          = DEF_A,
  parameter int DUMP_BASE  = 0,
  parameter int DUMP_COUNT = 256
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [A-1:0] mem_address_i,
  input  logic [31:0]  mem_in_data_i,
  input  logic         mem_WE_i,
  output logic [31:0]  mem_out_data_o,
  output logic         addr_err_o,
  input  logic         dump_start_i,
  output logic         dump_valid_o,
  input  logic         dump_ready_i,
  output logic [L-1:0] dump_data_o,
  output logic [A-1:0] dump_addr_o,
  output logic         dump_busy_o,
  output logic         dump_done_o
);

  localparam int AW = idx_bits(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(DUMP_COUNT - 1);

  logic          in_range, oob_q, ram_we, dump_ren;
  logic [L-1:0]  rd0;
  logic [A-1:0]  ptr;
  logic [CW-1:0] cnt;
  dump_state_t   state, state_nxt;
  logic          unused_ok;

  assign in_range  = (mem_address_i[A-1:AW] == '0);
  assign ram_we    = mem_WE_i && in_range;
  assign unused_ok = ^mem_in_data_i[31:L];

  byte_ram_2r1w #(.DEPTH(DEPTH), .L(L)) u_ram (
    .clk    (CLK),
    .rst    (RST),
    .we     (ram_we),
    .waddr  (mem_address_i[AW-1:0]),
    .wdata  (mem_in_data_i[L-1:0]),
    .raddr0 (mem_address_i[AW-1:0]),
    .rdata0 (rd0),
    .ren1   (dump_ren),
    .raddr1 (ptr[AW-1:0]),
    .rdata1 (dump_data_o)
  );

  // oob_q tracks the read in flight so an out-of-range read returns zero.
  always_ff @(posedge CLK) begin
    if (RST) begin
      oob_q      <= 1'b0;
      addr_err_o <= 1'b0;
    end else begin
      oob_q <= !in_range;
      if (!in_range) addr_err_o <= 1'b1;
    end
  end

  always_comb begin
    mem_out_data_o        = '0;
    mem_out_data_o[L-1:0] = oob_q ? '0 : rd0;
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (dump_start_i) state_nxt = FETCH;
      FETCH:   state_nxt = PRESENT;
      PRESENT: if (dump_ready_i) state_nxt = (cnt == LAST_CNT) ? DONE : FETCH;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    dump_ren     = (state == FETCH);
    dump_valid_o = (state == PRESENT);
    dump_busy_o  = (state != IDLE);
    dump_done_o  = (state == DONE);
  end

  // Pointer advances on acceptance; the address beat is latched alongside the data read.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr         <= '0;
      cnt         <= '0;
      dump_addr_o <= '0;
    end else begin
      case (state)
        IDLE: if (dump_start_i) begin
          ptr <= A'(DUMP_BASE);
          cnt <= '0;
        end
        FETCH: dump_addr_o <= ptr;
        PRESENT: if (dump_ready_i && cnt != LAST_CNT) begin
          ptr <= ptr + 1'b1;
          cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
